// File: rtl/fetch_control.sv
// Fetch-stage control: PC/IFID enables, redirects, load-use stalls, memory wait bubbles and halt.
// Optional performance counters are built only when FETCH_CONTROL_PERF_EN is defined.
module fetch_control #(
    parameter int unsigned IMEM_WAIT  = 0,
    parameter logic [31:0] HALT_INSTR = 32'h00100073
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instrucao,
    input  logic        id_ex_mem_read,
    input  logic [4:0]  id_ex_rd,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        mux_sel,
    output logic [31:0] pc_branch_value,
    output logic        load_pc,
    output logic        load_if_id_register,
    output logic        if_flush,
    output logic        id_ex_flush,
    output logic        halted,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [31:0] WAIT_LOAD = 32'(IMEM_WAIT);
    localparam state_t      POST_FETCH = (IMEM_WAIT == 0) ? RUN : WAIT;

    state_t      state, state_nx;
    logic [31:0] cnt, cnt_nx;
    logic        hazard;
    logic        halt_detect;

    assign hazard = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                    ((id_ex_rd == instrucao[19:15]) || (id_ex_rd == instrucao[24:20]));
    assign halt_detect = (instrucao == HALT_INSTR);

    assign pc_branch_value = branch_target;

    always_comb begin
        state_nx            = state;
        cnt_nx              = cnt;
        mux_sel             = 1'b0;
        load_pc             = 1'b0;
        load_if_id_register = 1'b0;
        if_flush            = 1'b0;
        id_ex_flush         = 1'b0;
        halted              = 1'b0;
        if (reset) begin
            state_nx = POST_FETCH;
            cnt_nx   = WAIT_LOAD;
        end else if (state == HALT) begin
            halted = 1'b1;
        end else begin
            mux_sel = branch_taken;
            if (branch_taken) begin
                load_pc             = 1'b1;
                load_if_id_register = 1'b1;
                if_flush            = 1'b1;
                id_ex_flush         = 1'b1;
                state_nx            = POST_FETCH;
                cnt_nx              = WAIT_LOAD;
            end else if (halt_detect) begin
                state_nx = HALT;
            end else if (hazard) begin
                // The memory wait keeps elapsing while the pipeline is stalled.
                id_ex_flush = 1'b1;
                if (state == WAIT) begin
                    cnt_nx = cnt - 32'd1;
                    if (cnt <= 32'd1) state_nx = RUN;
                end
            end else if (state == WAIT) begin
                load_if_id_register = 1'b1;
                if_flush            = 1'b1;
                cnt_nx              = cnt - 32'd1;
                if (cnt <= 32'd1) state_nx = RUN;
            end else begin
                load_pc             = 1'b1;
                load_if_id_register = 1'b1;
                state_nx            = POST_FETCH;
                cnt_nx              = WAIT_LOAD;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= POST_FETCH;
            cnt   <= WAIT_LOAD;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

`ifdef FETCH_CONTROL_PERF_EN
    logic        stall_ev;
    logic        flush_ev;
    logic [31:0] stall_q;
    logic [31:0] flush_q;

    assign flush_ev = (state != HALT) && branch_taken;
    assign stall_ev = (state != HALT) && !branch_taken && !halt_detect && hazard;

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_ev) stall_q <= stall_q + 32'd1;
            if (flush_ev) flush_q <= flush_q + 32'd1;
        end
    end

    assign stall_count = stall_q;
    assign flush_count = flush_q;
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule

// File: tb/tb_fetch_control.sv
// Scoreboard bench for fetch_control: two instances (IMEM_WAIT=0 and 2) share stimulus
// and are checked against a bubble-count reference model.
module tb_fetch_control;

    localparam logic [31:0] HALT_I = 32'h00100073;
    localparam logic [31:0] NOP    = 32'h00000013;

    typedef struct packed {
        logic        mux;
        logic [31:0] pbv;
        logic        lp;
        logic        li;
        logic        ifl;
        logic        idf;
        logic        hlt;
        logic [31:0] stall;
        logic [31:0] flush;
    } obs_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] instrucao;
    logic        id_ex_mem_read;
    logic [4:0]  id_ex_rd;
    logic        branch_taken;
    logic [31:0] branch_target;

    logic        mux0, lp0, li0, ifl0, idf0, hlt0;
    logic [31:0] pbv0, sc0, fc0;
    logic        mux2, lp2, li2, ifl2, idf2, hlt2;
    logic [31:0] pbv2, sc2, fc2;

    obs_t got [2];
    assign got[0] = {mux0, pbv0, lp0, li0, ifl0, idf0, hlt0, sc0, fc0};
    assign got[1] = {mux2, pbv2, lp2, li2, ifl2, idf2, hlt2, sc2, fc2};

    always #5 clock = ~clock;

    fetch_control #(.IMEM_WAIT(0), .HALT_INSTR(HALT_I)) u_w0 (
        .clock(clock), .reset(reset), .instrucao(instrucao),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .mux_sel(mux0), .pc_branch_value(pbv0), .load_pc(lp0),
        .load_if_id_register(li0), .if_flush(ifl0), .id_ex_flush(idf0),
        .halted(hlt0), .stall_count(sc0), .flush_count(fc0)
    );

    fetch_control #(.IMEM_WAIT(2), .HALT_INSTR(HALT_I)) u_w2 (
        .clock(clock), .reset(reset), .instrucao(instrucao),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .mux_sel(mux2), .pc_branch_value(pbv2), .load_pc(lp2),
        .load_if_id_register(li2), .if_flush(ifl2), .id_ex_flush(idf2),
        .halted(hlt2), .stall_count(sc2), .flush_count(fc2)
    );

    // Reference model: remaining wait bubbles, halted flag, event counts.
    int          wait_len [2] = '{0, 2};
    int          bub [2];
    bit          mhalt [2];
    logic [31:0] mstall [2];
    logic [31:0] mflush [2];

    obs_t q0 [$];
    obs_t q1 [$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    function automatic logic [31:0] mk(input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, 5'd7, 7'h33};
    endfunction

    function automatic obs_t model(input int k);
        obs_t e;
        bit   hz;
        e = '0;
        e.pbv = branch_target;
        hz = id_ex_mem_read && (id_ex_rd != 0) &&
             (id_ex_rd == instrucao[19:15] || id_ex_rd == instrucao[24:20]);
`ifdef FETCH_CONTROL_PERF_EN
        e.stall = mstall[k];
        e.flush = mflush[k];
`endif
        if (reset) begin
            mhalt[k]  = 0;
            bub[k]    = wait_len[k];
            mstall[k] = '0;
            mflush[k] = '0;
        end else if (mhalt[k]) begin
            e.hlt = 1'b1;
        end else begin
            e.mux = branch_taken;
            if (branch_taken) begin
                {e.lp, e.li, e.ifl, e.idf} = 4'b1111;
                mflush[k] = mflush[k] + 1;
                bub[k] = wait_len[k];
            end else if (instrucao == HALT_I) begin
                mhalt[k] = 1;
            end else if (hz) begin
                e.idf = 1'b1;
                mstall[k] = mstall[k] + 1;
                if (bub[k] > 0) bub[k]--;
            end else if (bub[k] > 0) begin
                e.li  = 1'b1;
                e.ifl = 1'b1;
                bub[k]--;
            end else begin
                e.lp = 1'b1;
                e.li = 1'b1;
                bub[k] = wait_len[k];
            end
        end
        return e;
    endfunction

    task automatic step(input bit r, input logic [31:0] ins, input bit mr,
                        input logic [4:0] rd, input bit bt, input logic [31:0] tg,
                        input bit chk);
        obs_t e0, e1;
        @(negedge clock);
        reset          = r;
        instrucao      = ins;
        id_ex_mem_read = mr;
        id_ex_rd       = rd;
        branch_taken   = bt;
        branch_target  = tg;
        #1;
        e0 = model(0);
        e1 = model(1);
        if (chk) begin
            q0.push_back(e0);
            q1.push_back(e1);
        end
    endtask

    task automatic compare(input int k, input obs_t g, input obs_t e);
        total++;
        if (g !== e) begin
            bad++;
            $display("FAIL outputs w=%0d cyc=%0d got mux=%b pbv=%h lp=%b li=%b iff=%b idf=%b hlt=%b sc=%0d fc=%0d exp mux=%b pbv=%h lp=%b li=%b iff=%b idf=%b hlt=%b sc=%0d fc=%0d",
                     wait_len[k], cyc, g.mux, g.pbv, g.lp, g.li, g.ifl, g.idf, g.hlt, g.stall, g.flush,
                     e.mux, e.pbv, e.lp, e.li, e.ifl, e.idf, e.hlt, e.stall, e.flush);
        end
    endtask

    // Monitor: outputs are combinational and presented every cycle.
    initial begin
        forever begin
            @(negedge clock);
            #2;
            cyc++;
            if (q0.size() > 0) compare(0, got[0], q0.pop_front());
            if (q1.size() > 0) compare(1, got[1], q1.pop_front());
        end
    end

    initial begin
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] ins;
        bit          r, bt, mr;
        step(1, NOP, 0, 0, 0, 0, 0);
        step(1, NOP, 0, 0, 0, 32'h10, 1);
        for (int unsigned i = 0; i < 6; i++) step(0, NOP, 0, 0, 0, 32'h20, 1);
        // Load-use on rs1, then rd=0 which must not stall.
        step(0, mk(5'd5, 5'd9), 1, 5'd5, 0, 0, 1);
        step(0, mk(5'd0, 5'd0), 1, 5'd0, 0, 0, 1);
        step(0, mk(5'd3, 5'd7), 1, 5'd7, 0, 0, 1);
        // Hazard and redirect in the same cycle.
        step(0, mk(5'd5, 5'd1), 1, 5'd5, 1, 32'h40, 1);
        step(1, NOP, 0, 0, 0, 0, 1);
        for (int unsigned i = 0; i < 4; i++) step(0, NOP, 0, 0, 0, 0, 1);
        step(0, NOP, 0, 0, 1, 32'h80, 1);
        for (int unsigned i = 0; i < 4; i++) step(0, NOP, 0, 0, 0, 0, 1);
        // Halt, redirect ignored while halted, reset releases.
        step(0, HALT_I, 0, 0, 0, 0, 1);
        step(0, NOP, 0, 0, 1, 32'h44, 1);
        step(0, NOP, 1, 5'd0, 1, 32'h48, 1);
        step(1, HALT_I, 0, 0, 1, 32'h4c, 1);
        for (int unsigned i = 0; i < 3; i++) step(0, NOP, 0, 0, 0, 0, 1);
        for (int unsigned i = 0; i < 400; i++) begin
            r   = ($urandom_range(0, 99) < 4);
            bt  = ($urandom_range(0, 99) < 20);
            mr  = $urandom_range(0, 1) == 1;
            rd  = 5'($urandom_range(0, 7));
            rs1 = ($urandom_range(0, 99) < 35) ? rd : 5'($urandom_range(0, 31));
            rs2 = ($urandom_range(0, 99) < 20) ? rd : 5'($urandom_range(0, 31));
            ins = ($urandom_range(0, 99) < 4) ? HALT_I : {7'($urandom), rs2, rs1, 15'($urandom)};
            step(r, ins, mr, rd, bt, $urandom, 1);
        end
        step(0, NOP, 0, 0, 0, 0, 0);
        step(0, NOP, 0, 0, 0, 0, 0);
        total++;
        if (q0.size() + q1.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d pending exp=0", q0.size() + q1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
